alu_issue_stage: RTL and testbench

- ID/EX boundary block that drives the ALU operand interface: decodes a MIPS instruction into a 3-bit ALU operation code, selects and forwards the A and B operands, and registers them for the EX stage.
- It is the producer side of the ALU's Adat/Bdat/ALUoper interface.
- It carries a valid/ready pipeline-register handshake, stall and flush.

---
 rtl/alu_pkg.sv | 70 +++++++
 rtl/alu_decode.sv | 58 +++++
 rtl/alu_issue_stage.sv | 163 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - ALU_* 3-bit operation codes driven on alu_oper
//   - MIPS opcode / funct constants used by the decoder
//   - dec_ctrl_t: decoded control (operation, operand selects, write-back info)
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Operand A: rs, instruction shamt, low 5 bits of rs, constant 16 (lui), or 0.
  typedef enum logic [2:0] {A_ZERO, A_RS, A_SHAMT, A_RS5, A_SIXTEEN} a_sel_e;
  // Operand B: rt, sign/zero-extended immediate, or 0.
  typedef enum logic [1:0] {B_ZERO, B_RT, B_SEXT, B_ZEXT} b_sel_e;
  typedef enum logic {WR_RD, WR_RT} wr_sel_e;

  typedef struct packed {
    logic [2:0] oper;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    logic       wr_en;
    wr_sel_e    wr_sel;
    logic       ovf_trap;
    logic       illegal;
  } dec_ctrl_t;

  localparam dec_ctrl_t CTRL_ILLEGAL = '{oper: ALU_AND, a_sel: A_ZERO, b_sel: B_ZERO,
                                         wr_en: 1'b0, wr_sel: WR_RD, ovf_trap: 1'b0,
                                         illegal: 1'b1};

  // Common shape of every I-type: A=rs, destination rt, writes a register.
  function automatic dec_ctrl_t ctrl_itype(input logic [2:0] oper, input b_sel_e b_sel);
    dec_ctrl_t c;
    c = '{oper: oper, a_sel: A_RS, b_sel: b_sel, wr_en: 1'b1, wr_sel: WR_RT,
          ovf_trap: 1'b0, illegal: 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS instruction decoder for the ALU issue stage.
//   instr : raw 32-bit instruction word
//   ctrl  : decoded control (ALU op, operand selects, write-back, ovf/illegal)
// Register-0 suppression of wr_en is applied by the caller, which knows the index.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_ctrl_t   ctrl
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    ctrl = CTRL_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        ctrl = '{oper: ALU_AND, a_sel: A_RS, b_sel: B_RT, wr_en: 1'b1, wr_sel: WR_RD,
                 ovf_trap: 1'b0, illegal: 1'b0};
        case (funct)
          FN_ADD:  begin ctrl.oper = ALU_ADD; ctrl.ovf_trap = 1'b1; end
          FN_ADDU: ctrl.oper = ALU_ADD;
          FN_SUB:  begin ctrl.oper = ALU_SUB; ctrl.ovf_trap = 1'b1; end
          FN_SUBU: ctrl.oper = ALU_SUB;
          FN_AND:  ctrl.oper = ALU_AND;
          FN_OR:   ctrl.oper = ALU_OR;
          FN_SLT:  ctrl.oper = ALU_SLT;
          FN_SLL:  begin ctrl.oper = ALU_SLL; ctrl.a_sel = A_SHAMT; end
          FN_SRL:  begin ctrl.oper = ALU_SRL; ctrl.a_sel = A_SHAMT; end
          FN_SRA:  begin ctrl.oper = ALU_SRA; ctrl.a_sel = A_SHAMT; end
          FN_SLLV: begin ctrl.oper = ALU_SLL; ctrl.a_sel = A_RS5; end
          FN_SRLV: begin ctrl.oper = ALU_SRL; ctrl.a_sel = A_RS5; end
          FN_SRAV: begin ctrl.oper = ALU_SRA; ctrl.a_sel = A_RS5; end
          default: ctrl = CTRL_ILLEGAL;
        endcase
      end
      OP_ADDI:  begin ctrl = ctrl_itype(ALU_ADD, B_SEXT); ctrl.ovf_trap = 1'b1; end
      OP_ADDIU: ctrl = ctrl_itype(ALU_ADD, B_SEXT);
      OP_SLTI:  ctrl = ctrl_itype(ALU_SLT, B_SEXT);
      OP_ANDI:  ctrl = ctrl_itype(ALU_AND, B_ZEXT);
      OP_ORI:   ctrl = ctrl_itype(ALU_OR,  B_ZEXT);
      // lui is issued as (imm << 16).
      OP_LUI:   begin ctrl = ctrl_itype(ALU_SLL, B_ZEXT); ctrl.a_sel = A_SIXTEEN; end
      OP_LW:    ctrl = ctrl_itype(ALU_ADD, B_SEXT);
      OP_SW:    begin ctrl = ctrl_itype(ALU_ADD, B_SEXT); ctrl.wr_en = 1'b0; end
      OP_BEQ, OP_BNE: begin
        ctrl = ctrl_itype(ALU_SUB, B_RT);
        ctrl.wr_en = 1'b0;
      end
      default:  ctrl = CTRL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX pipeline register driving the ALU operand interface.
//   in_valid/in_ready   : handshake from ID (in_ready = !out_valid || out_ready)
//   instr, rs/rt_data   : instruction and register-file reads
//   ex_*/mem_*          : forwarding sources (EX has priority over MEM)
//   flush               : drops the held and the incoming instruction
//   out_valid/out_ready : handshake to EX
//   alu_a/alu_b/alu_oper, wr_en/wr_reg, ovf_trap, illegal : registered outputs
// Optional macro ALU_ISSUE_FWD_EN enables operand forwarding; without it the
// ex_*/mem_* inputs are ignored and rs_data/rt_data feed the muxes directly.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            ex_wr_en,
  input  logic [REGW-1:0] ex_wr_reg,
  input  logic [XLEN-1:0] ex_wr_data,
  input  logic            mem_wr_en,
  input  logic [REGW-1:0] mem_wr_reg,
  input  logic [XLEN-1:0] mem_wr_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_oper,
  output logic            wr_en,
  output logic [REGW-1:0] wr_reg,
  output logic            ovf_trap,
  output logic            illegal
);

  dec_ctrl_t       ctrl;
  logic [REGW-1:0] rs_idx, rt_idx, rd_idx, dest;
  logic [XLEN-1:0] rs_fwd, rt_fwd, a_ld, b_ld;
  logic            load;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]      alu_oper_q, alu_oper_d;
  logic            wr_en_q, wr_en_d, ovf_trap_q, ovf_trap_d, illegal_q, illegal_d;
  logic [REGW-1:0] wr_reg_q, wr_reg_d;

  alu_decode u_decode (.instr(instr), .ctrl(ctrl));

  assign rs_idx = REGW'(instr[25:21]);
  assign rt_idx = REGW'(instr[20:16]);
  assign rd_idx = REGW'(instr[15:11]);

`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    rs_fwd = rs_data;
    if (ex_wr_en && ex_wr_reg != '0 && ex_wr_reg == rs_idx)
      rs_fwd = ex_wr_data;
    else if (mem_wr_en && mem_wr_reg != '0 && mem_wr_reg == rs_idx)
      rs_fwd = mem_wr_data;
    rt_fwd = rt_data;
    if (ex_wr_en && ex_wr_reg != '0 && ex_wr_reg == rt_idx)
      rt_fwd = ex_wr_data;
    else if (mem_wr_en && mem_wr_reg != '0 && mem_wr_reg == rt_idx)
      rt_fwd = mem_wr_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_wr_en, ex_wr_reg, ex_wr_data, mem_wr_en, mem_wr_reg, mem_wr_data};
  assign rs_fwd = rs_data;
  assign rt_fwd = rt_data;
`endif

  // Forwarded values feed the muxes, so variable shifts mask the forwarded rs.
  always_comb begin
    case (ctrl.a_sel)
      A_RS:      a_ld = rs_fwd;
      A_SHAMT:   a_ld = XLEN'(instr[10:6]);
      A_RS5:     a_ld = XLEN'(rs_fwd[4:0]);
      A_SIXTEEN: a_ld = XLEN'(16);
      default:   a_ld = '0;
    endcase
    case (ctrl.b_sel)
      B_RT:    b_ld = rt_fwd;
      B_SEXT:  b_ld = {{(XLEN-16){instr[15]}}, instr[15:0]};
      B_ZEXT:  b_ld = {{(XLEN-16){1'b0}}, instr[15:0]};
      default: b_ld = '0;
    endcase
  end

  assign dest     = (ctrl.wr_sel == WR_RT) ? rt_idx : rd_idx;
  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_oper_d  = alu_oper_q;
    wr_en_d     = wr_en_q;
    wr_reg_d    = wr_reg_q;
    ovf_trap_d  = ovf_trap_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
      alu_a_d     = '0;
      alu_b_d     = '0;
      alu_oper_d  = ALU_AND;
      wr_en_d     = 1'b0;
      wr_reg_d    = '0;
      ovf_trap_d  = 1'b0;
      illegal_d   = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      alu_a_d     = a_ld;
      alu_b_d     = b_ld;
      alu_oper_d  = ctrl.oper;
      wr_en_d     = ctrl.wr_en && (dest != '0);
      wr_reg_d    = dest;
      ovf_trap_d  = ctrl.ovf_trap;
      illegal_d   = ctrl.illegal;
    end else if (out_ready) begin
      // Transfer with nothing behind it: only the valid bit drops.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_oper_q  <= ALU_AND;
      wr_en_q     <= 1'b0;
      wr_reg_q    <= '0;
      ovf_trap_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_oper_q  <= alu_oper_d;
      wr_en_q     <= wr_en_d;
      wr_reg_q    <= wr_reg_d;
      ovf_trap_q  <= ovf_trap_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_oper  = alu_oper_q;
  assign wr_en     = wr_en_q;
  assign wr_reg    = wr_reg_q;
  assign ovf_trap  = ovf_trap_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a random
// run, all compared against an instruction-level reference model.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, rs_data, rt_data, ex_wr_data, mem_wr_data, alu_a, alu_b;
  logic        ex_wr_en, mem_wr_en, wr_en, ovf_trap, illegal;
  logic [4:0]  ex_wr_reg, mem_wr_reg, wr_reg;
  logic [2:0]  alu_oper;

  int checks = 0;
  int errors = 0;

  // Model of the registered outputs.
  bit          m_valid;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic        m_we, m_ovf, m_ill;
  logic [4:0]  m_wr;

  alu_issue_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data),
    .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_wr_data(mem_wr_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .wr_en(wr_en),
    .wr_reg(wr_reg), .ovf_trap(ovf_trap), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] regv);
    if (FWD && ex_wr_en && ex_wr_reg != 0 && ex_wr_reg == idx) return ex_wr_data;
    if (FWD && mem_wr_en && mem_wr_reg != 0 && mem_wr_reg == idx) return mem_wr_data;
    return regv;
  endfunction

  task automatic ref_decode(input logic [31:0] ins, output logic [2:0] op_o,
                            output logic [31:0] a_o, output logic [31:0] b_o,
                            output logic we_o, output logic [4:0] wr_o,
                            output logic ovf_o, output logic ill_o);
    logic [31:0] rsv, rtv, sx, zx;
    bit ok, writes;
    rsv = fwd_val(ins[25:21], rs_data);
    rtv = fwd_val(ins[20:16], rt_data);
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    ok = 1; writes = 1; ovf_o = 0; a_o = rsv; b_o = rtv; op_o = 3'd0;
    if (ins[31:26] == 6'h00) begin
      wr_o = ins[15:11];
      case (ins[5:0])
        6'h20: begin op_o = 3'd2; ovf_o = 1; end
        6'h21: op_o = 3'd2;
        6'h22: begin op_o = 3'd6; ovf_o = 1; end
        6'h23: op_o = 3'd6;
        6'h24: op_o = 3'd0;
        6'h25: op_o = 3'd1;
        6'h2A: op_o = 3'd7;
        6'h00: begin op_o = 3'd3; a_o = {27'b0, ins[10:6]}; end
        6'h02: begin op_o = 3'd4; a_o = {27'b0, ins[10:6]}; end
        6'h03: begin op_o = 3'd5; a_o = {27'b0, ins[10:6]}; end
        6'h04: begin op_o = 3'd3; a_o = rsv % 32; end
        6'h06: begin op_o = 3'd4; a_o = rsv % 32; end
        6'h07: begin op_o = 3'd5; a_o = rsv % 32; end
        default: ok = 0;
      endcase
    end else begin
      wr_o = ins[20:16];
      case (ins[31:26])
        6'h08: begin op_o = 3'd2; b_o = sx; ovf_o = 1; end
        6'h09: begin op_o = 3'd2; b_o = sx; end
        6'h0A: begin op_o = 3'd7; b_o = sx; end
        6'h0C: begin op_o = 3'd0; b_o = zx; end
        6'h0D: begin op_o = 3'd1; b_o = zx; end
        6'h0F: begin op_o = 3'd3; a_o = 32'd16; b_o = zx; end
        6'h23: begin op_o = 3'd2; b_o = sx; end
        6'h2B: begin op_o = 3'd2; b_o = sx; writes = 0; end
        6'h04, 6'h05: begin op_o = 3'd6; writes = 0; end
        default: ok = 0;
      endcase
    end
    if (!ok) begin op_o = 3'd0; a_o = 0; b_o = 0; ovf_o = 0; end
    we_o  = ok && writes && (wr_o != 0);
    ill_o = !ok;
  endtask

  // One clock: predict next registered state from current inputs, then advance.
  task automatic tick();
    logic [2:0]  n_op;
    logic [31:0] n_a, n_b;
    logic        n_we, n_ovf, n_ill;
    logic [4:0]  n_wr;
    bit ld;
    ld = in_valid && (!m_valid || out_ready);
    ref_decode(instr, n_op, n_a, n_b, n_we, n_wr, n_ovf, n_ill);
    @(posedge clk);
    if (rst || flush) begin
      m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_we = 0; m_wr = 0; m_ovf = 0; m_ill = 0;
    end else if (ld) begin
      m_valid = 1; m_a = n_a; m_b = n_b; m_op = n_op; m_we = n_we; m_wr = n_wr;
      m_ovf = n_ovf; m_ill = n_ill;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; out_ready = 1; flush = 0; ex_wr_en = 0; mem_wr_en = 0;
    ex_wr_reg = 0; mem_wr_reg = 0; ex_wr_data = 0; mem_wr_data = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; out_ready = 1; flush = 0;
    instr = {6'h08, 5'd1, 5'd2, 16'hFFFF}; rs_data = 5; rt_data = 9;
    ex_wr_en = 0; ex_wr_reg = 0; ex_wr_data = 0; mem_wr_en = 0; mem_wr_reg = 0; mem_wr_data = 0;
    tick(); tick();
    checks++; if ({out_valid, alu_a, alu_b, alu_oper, wr_en, wr_reg, ovf_trap, illegal} !== '0) begin
      errors++; $display("FAIL reset_outputs got v%b a%h b%h op%h we%b wr%0d ovf%b ill%b exp all zero",
        out_valid, alu_a, alu_b, alu_oper, wr_en, wr_reg, ovf_trap, illegal); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_addi();
    rst = 0; in_valid = 1; out_ready = 1;
    instr = {6'h08, 5'd1, 5'd2, 16'hFFFF}; rs_data = 5;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b exp 1", out_valid); end
    checks++; if (alu_oper !== 3'b010) begin errors++; $display("FAIL addi_oper got %b exp 010", alu_oper); end
    checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL addi_a got %h exp 5", alu_a); end
    checks++; if (alu_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_b got %h exp ffffffff", alu_b); end
    checks++; if (wr_reg !== 5'd2 || wr_en !== 1'b1) begin errors++; $display("FAIL addi_wr got %0d/%b exp 2/1", wr_reg, wr_en); end
    checks++; if (ovf_trap !== 1'b1) begin errors++; $display("FAIL addi_ovf got %b exp 1", ovf_trap); end
    in_valid = 0; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_shift_lui();
    in_valid = 1; out_ready = 1; rt_data = 1; rs_data = 32'hDEAD;
    instr = {6'h00, 5'd0, 5'd4, 5'd3, 5'd7, 6'h00};
    tick();
    checks++; if (alu_a !== 32'd7 || alu_b !== 32'd1 || alu_oper !== 3'b011) begin errors++;
      $display("FAIL sll got a%h b%h op%b exp a7 b1 op011", alu_a, alu_b, alu_oper); end
    checks++; if (ovf_trap !== 1'b0 || wr_reg !== 5'd3) begin errors++;
      $display("FAIL sll_ctl got ovf%b wr%0d exp 0/3", ovf_trap, wr_reg); end
    instr = {6'h0F, 5'd0, 5'd5, 16'h1234};
    tick();
    checks++; if (alu_a !== 32'd16 || alu_b !== 32'h00001234 || alu_oper !== 3'b011) begin errors++;
      $display("FAIL lui got a%h b%h op%b exp a10 b1234 op011", alu_a, alu_b, alu_oper); end
    checks++; if (wr_reg !== 5'd5 || wr_en !== 1'b1) begin errors++;
      $display("FAIL lui_wr got %0d/%b exp 5/1", wr_reg, wr_en); end
  endtask

  task automatic test_forwarding();
    logic [31:0] e;
    in_valid = 1; out_ready = 1; rs_data = 32'h11; rt_data = 32'h11;
    instr = {6'h00, 5'd1, 5'd1, 5'd6, 5'd0, 6'h20};
    ex_wr_en = 1; ex_wr_reg = 1; ex_wr_data = 32'hAA;
    mem_wr_en = 1; mem_wr_reg = 1; mem_wr_data = 32'hBB;
    tick();
    e = FWD ? 32'hAA : 32'h11;
    checks++; if (alu_a !== e || alu_b !== e) begin errors++;
      $display("FAIL fwd_ex got a%h b%h exp %h", alu_a, alu_b, e); end
    ex_wr_reg = 0; tick();
    e = FWD ? 32'hBB : 32'h11;
    checks++; if (alu_a !== e || alu_b !== e) begin errors++;
      $display("FAIL fwd_mem got a%h b%h exp %h", alu_a, alu_b, e); end
    instr = {6'h00, 5'd0, 5'd0, 5'd6, 5'd0, 6'h20}; mem_wr_reg = 0;
    tick();
    checks++; if (alu_a !== 32'h11 || alu_b !== 32'h11) begin errors++;
      $display("FAIL fwd_reg0 got a%h b%h exp 11", alu_a, alu_b); end
    quiet();
  endtask

  task automatic test_stall();
    in_valid = 1; out_ready = 0; rs_data = 100; rt_data = 23;
    instr = {6'h00, 5'd2, 5'd3, 5'd7, 5'd0, 6'h20};
    tick();
    checks++; if (out_valid !== 1'b1 || alu_a !== 32'd100) begin errors++;
      $display("FAIL stall_load got v%b a%h exp 1/64", out_valid, alu_a); end
    instr = {6'h00, 5'd2, 5'd3, 5'd8, 5'd0, 6'h22}; rs_data = 50; rt_data = 7;
    ex_wr_en = 1; ex_wr_reg = 2; ex_wr_data = 999;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d got %b exp 0", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || alu_a !== 32'd100 || alu_b !== 32'd23 ||
                    alu_oper !== 3'b010 || wr_reg !== 5'd7) begin errors++;
        $display("FAIL stall_hold c%0d got v%b a%h b%h op%b wr%0d exp 1/64/17/010/7",
                 k, out_valid, alu_a, alu_b, alu_oper, wr_reg); end
    end
    ex_wr_en = 0; out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || alu_oper !== 3'b110 || alu_a !== 32'd50 ||
                  alu_b !== 32'd7 || wr_reg !== 5'd8) begin errors++;
      $display("FAIL no_bubble got v%b op%b a%h b%h wr%0d exp 1/110/32/7/8",
               out_valid, alu_oper, alu_a, alu_b, wr_reg); end
    quiet();
  endtask

  task automatic test_flush();
    in_valid = 1; out_ready = 0; rs_data = 3; rt_data = 4;
    instr = {6'h00, 5'd2, 5'd3, 5'd9, 5'd0, 6'h21};
    tick();
    flush = 1; instr = {6'h09, 5'd1, 5'd10, 16'h0042};
    tick();
    checks++; if (out_valid !== 1'b0 || wr_en !== 1'b0) begin errors++;
      $display("FAIL flush got v%b we%b exp 0/0", out_valid, wr_en); end
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got v%b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    in_valid = 1; out_ready = 1; rs_data = 32'h1234; rt_data = 32'h5678;
    instr = {6'h3F, 5'd1, 5'd2, 16'h00FF};
    tick();
    checks++; if (illegal !== 1'b1 || wr_en !== 1'b0 || alu_oper !== 3'b000 ||
                  alu_a !== 0 || alu_b !== 0 || out_valid !== 1'b1) begin errors++;
      $display("FAIL illegal got ill%b we%b op%b a%h b%h v%b exp 1/0/000/0/0/1",
               illegal, wr_en, alu_oper, alu_a, alu_b, out_valid); end
  endtask

  task automatic test_srav();
    in_valid = 1; out_ready = 1; rs_data = 32'h25; rt_data = 32'h80000000;
    instr = {6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h07};
    tick();
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'h80000000 || alu_oper !== 3'b101) begin errors++;
      $display("FAIL srav got a%h b%h op%b exp 5/80000000/101", alu_a, alu_b, alu_oper); end
    checks++; if (illegal !== 1'b0 || wr_en !== 1'b1 || wr_reg !== 5'd4) begin errors++;
      $display("FAIL srav_ctl got ill%b we%b wr%0d exp 0/1/4", illegal, wr_en, wr_reg); end
    quiet();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C,
                             6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    logic [5:0] fns [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20,
                             6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h01};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ops[$urandom_range(13)];
    w[25:21] = 5'($urandom_range(7));
    w[20:16] = 5'($urandom_range(7));
    if (w[31:26] == 6'h00) begin
      w[15:11] = 5'($urandom_range(7));
      w[5:0]   = fns[$urandom_range(13)];
    end
    return w;
  endfunction

  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(3) != 0); out_ready = ($urandom_range(2) != 0);
      flush = ($urandom_range(19) == 0);
      instr = gen_instr(); rs_data = $urandom; rt_data = $urandom;
      ex_wr_en = $urandom_range(1); ex_wr_reg = 5'($urandom_range(7)); ex_wr_data = $urandom;
      mem_wr_en = $urandom_range(1); mem_wr_reg = 5'($urandom_range(7)); mem_wr_data = $urandom;
      #1;
      exp_rdy = !m_valid || out_ready;
      checks++; if (in_ready !== exp_rdy) begin errors++;
        $display("FAIL rnd_in_ready i%0d got %b exp %b", i, in_ready, exp_rdy); end
      tick();
      checks++; if (out_valid !== m_valid) begin errors++;
        $display("FAIL rnd_valid i%0d got %b exp %b", i, out_valid, m_valid); end
      checks++; if (alu_a !== m_a || alu_b !== m_b || alu_oper !== m_op) begin errors++;
        $display("FAIL rnd_operands i%0d got a%h b%h op%b exp a%h b%h op%b",
                 i, alu_a, alu_b, alu_oper, m_a, m_b, m_op); end
      checks++; if (wr_en !== m_we || ovf_trap !== m_ovf || illegal !== m_ill) begin errors++;
        $display("FAIL rnd_ctl i%0d got we%b ovf%b ill%b exp we%b ovf%b ill%b",
                 i, wr_en, ovf_trap, illegal, m_we, m_ovf, m_ill); end
      if (!m_ill) begin
        checks++; if (wr_reg !== m_wr) begin errors++;
          $display("FAIL rnd_wr_reg i%0d got %0d exp %0d", i, wr_reg, m_wr); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_shift_lui();
    test_forwarding();
    test_stall();
    test_flush();
    test_illegal();
    test_srav();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
